datapath_pipe: RTL and testbench

Parametrised, pipelined successor of the combinational N-bit signed datapath. It accepts operand pairs and a 3-bit opcode over a valid/ready handshake and executes in a two-stage pipeline. It adds a signed multiply, a wide multiply-accumulate register for neuron dot products, optional output saturation and a signed-overflow flag. It sits between the operand fetch logic and the result writeback of the NeuroAccel arithmetic path.

---
 rtl/datapath_pipe.sv | 175 +++++++++++++++++
 tb/tb_datapath_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe.sv
// Two-stage pipelined signed datapath: ALU ops, signed multiply and a wide MAC
// accumulator behind valid/ready handshakes, with optional N-bit saturation of Y.
module datapath_pipe #(
    parameter int N     = 16,
    parameter int ACC_W = 40,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     Y,
    output logic             co,
    output logic             ovf,
    output logic [ACC_W-1:0] acc_out
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_MUL   = 3'b101,
        OP_MAC   = 3'b110,
        OP_RDCLR = 3'b111
    } op_e;

    localparam logic [N-1:0] Y_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] Y_MIN = {1'b1, {(N-1){1'b0}}};

    // Stage 1 state
    logic                  s1_valid_q;
    logic [N-1:0]          s1_a_q;
    logic [N-1:0]          s1_b_q;
    op_e                   s1_op_q;
    logic signed [2*N-1:0] s1_prod_q;

    // Stage 2 (output) state
    logic                  out_valid_q;
    logic [N-1:0]          y_q;
    logic                  co_q;
    logic                  ovf_q;
    logic [ACC_W-1:0]      acc_q;

    logic                  adv1;
    logic                  adv2;
    logic signed [2*N-1:0] a_ext;
    logic signed [2*N-1:0] b_ext;
    logic signed [2*N-1:0] prod_d;
    logic [N:0]            sum_ext;
    logic [N:0]            diff_ext;
    logic signed [ACC_W-1:0] prod_acc;
    logic [ACC_W-1:0]      mac_sum;
    logic                  prod_fits;
    logic                  mac_fits;
    logic                  acc_fits;

    logic [N-1:0]          y_d;
    logic                  co_d;
    logic                  ovf_d;
    logic [ACC_W-1:0]      acc_d;

    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1 && !rst;

    assign a_ext  = {{N{A[N-1]}}, A};
    assign b_ext  = {{N{B[N-1]}}, B};
    assign prod_d = a_ext * b_ext;

    assign sum_ext  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign diff_ext = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{N{1'b0}}, 1'b1};

    assign prod_acc = ACC_W'(s1_prod_q);
    assign mac_sum  = acc_q + prod_acc;

    // A value fits in signed N bits when every bit from N-1 upward equals the sign.
    assign prod_fits = (&s1_prod_q[2*N-1:N-1]) | ~(|s1_prod_q[2*N-1:N-1]);
    assign mac_fits  = (&mac_sum[ACC_W-1:N-1]) | ~(|mac_sum[ACC_W-1:N-1]);
    assign acc_fits  = (&acc_q[ACC_W-1:N-1])   | ~(|acc_q[ACC_W-1:N-1]);

    function automatic logic [N-1:0] sat_or_wrap(input logic fits, input logic neg,
                                                 input logic [N-1:0] low);
        if ((SAT != 0) && !fits) begin
            return neg ? Y_MIN : Y_MAX;
        end
        return low;
    endfunction

    always_comb begin
        y_d   = '0;
        co_d  = 1'b0;
        ovf_d = 1'b0;
        acc_d = acc_q;
        case (s1_op_q)
            OP_ADD: begin
                co_d  = sum_ext[N];
                ovf_d = (s1_a_q[N-1] == s1_b_q[N-1]) && (sum_ext[N-1] != s1_a_q[N-1]);
                y_d   = sat_or_wrap(!ovf_d, s1_a_q[N-1], sum_ext[N-1:0]);
            end
            OP_SUB: begin
                co_d  = diff_ext[N];
                ovf_d = (s1_a_q[N-1] != s1_b_q[N-1]) && (diff_ext[N-1] != s1_a_q[N-1]);
                y_d   = sat_or_wrap(!ovf_d, s1_a_q[N-1], diff_ext[N-1:0]);
            end
            OP_AND: y_d = s1_a_q & s1_b_q;
            OP_OR:  y_d = s1_a_q | s1_b_q;
            OP_XOR: y_d = s1_a_q ^ s1_b_q;
            OP_MUL: begin
                ovf_d = !prod_fits;
                y_d   = sat_or_wrap(prod_fits, s1_prod_q[2*N-1], s1_prod_q[N-1:0]);
            end
            OP_MAC: begin
                acc_d = mac_sum;
                ovf_d = (acc_q[ACC_W-1] == prod_acc[ACC_W-1]) &&
                        (mac_sum[ACC_W-1] != acc_q[ACC_W-1]);
                y_d   = sat_or_wrap(mac_fits, mac_sum[ACC_W-1], mac_sum[N-1:0]);
            end
            OP_RDCLR: begin
                acc_d = '0;
                y_d   = sat_or_wrap(acc_fits, acc_q[ACC_W-1], acc_q[N-1:0]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_ADD;
            s1_prod_q   <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_a_q    <= A;
                    s1_b_q    <= B;
                    s1_op_q   <= op_e'(opcode);
                    s1_prod_q <= prod_d;
                end
            end
            // The accumulator moves only with the beat that enters stage 2, so a
            // following MAC in stage 1 always sees the updated value.
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    y_q   <= y_d;
                    co_q  <= co_d;
                    ovf_q <= ovf_d;
                    acc_q <= acc_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Y         = y_q;
    assign co        = co_q;
    assign ovf       = ovf_q;
    assign acc_out   = acc_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: two instances (wrap and saturate) share stimulus; results are
// checked against a vector table and an arithmetic reference model with a scoreboard.
module tb_datapath_pipe;

    localparam int N     = 16;
    localparam int ACC_W = 40;
    localparam longint YMAX = 32767;
    localparam longint YMIN = -32768;
    localparam longint AMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ACC_W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [N-1:0]     A = '0;
    logic [N-1:0]     B = '0;
    logic [2:0]       opcode = '0;
    logic             in_ready0, in_ready1, out_valid0, out_valid1;
    logic [N-1:0]     y0, y1;
    logic             co0, co1, ovf0, ovf1;
    logic [ACC_W-1:0] acc0, acc1;

    datapath_pipe #(.N(N), .ACC_W(ACC_W), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .A(A), .B(B), .opcode(opcode), .out_valid(out_valid0), .out_ready(out_ready),
        .Y(y0), .co(co0), .ovf(ovf0), .acc_out(acc0));

    datapath_pipe #(.N(N), .ACC_W(ACC_W), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .A(A), .B(B), .opcode(opcode), .out_valid(out_valid1), .out_ready(out_ready),
        .Y(y1), .co(co1), .ovf(ovf1), .acc_out(acc1));

    typedef struct {
        longint y_wrap;
        longint y_sat;
        bit     co;
        bit     ovf;
        longint acc;
    } res_t;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        longint       yw;
        longint       ys;
        bit           co;
        bit           ovf;
        longint       acc;
    } vec_t;

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    longint m_acc = 0;
    bit     last_acc, last_cons;
    logic   snap_valid, snap_ready;
    logic signed [63:0] snap_y;
    res_t   sb[$];
    res_t   got_q[$];
    int     cons_cyc_q[$];
    vec_t   tbl[19];
    int     acc_cyc[8];
    int     bp_i;
    int     n_ovf;

    task automatic chk(input string name, input logic signed [63:0] act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m > ((longint'(1) << (w - 1)) - 1)) m = m - (longint'(1) << w);
        return m;
    endfunction

    // Reference semantics in plain integer arithmetic.
    function automatic res_t model(input logic [2:0] op, input longint a, input longint b,
                                   input longint acc);
        res_t   r;
        longint t;
        r.co = 0; r.ovf = 0; r.acc = acc; t = 0;
        case (op)
            3'd0: begin
                t = a + b;
                r.co  = ((a & 64'hFFFF) + (b & 64'hFFFF)) > 65535;
                r.ovf = (t > YMAX) || (t < YMIN);
            end
            3'd1: begin
                t = a - b;
                r.co  = (a & 64'hFFFF) >= (b & 64'hFFFF);
                r.ovf = (t > YMAX) || (t < YMIN);
            end
            3'd2: t = a & b;
            3'd3: t = a | b;
            3'd4: t = a ^ b;
            3'd5: begin
                t = a * b;
                r.ovf = (t > YMAX) || (t < YMIN);
            end
            3'd6: begin
                t = acc + a * b;
                r.ovf = (t > AMAX) || (t < AMIN);
                t = wrapw(t, ACC_W);
                r.acc = t;
            end
            default: begin
                t = acc;
                r.acc = 0;
            end
        endcase
        r.y_wrap = wrapw(t, N);
        r.y_sat  = (t > YMAX) ? YMAX : ((t < YMIN) ? YMIN : t);
        return r;
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock cycle: drive inputs, observe at the falling edge, score, advance.
    task automatic tick(input bit v, input logic [2:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input bit ordy);
        res_t e;
        res_t g;
        in_valid = v; opcode = op; A = a; B = b; out_ready = ordy;
        @(negedge clk);
        cyc++;
        last_acc   = in_valid && in_ready0;
        last_cons  = out_valid0 && out_ready;
        snap_valid = out_valid0;
        snap_ready = in_ready0;
        snap_y     = $signed(y0);
        if (last_cons) begin
            g.y_wrap = longint'($signed(y0));
            g.y_sat  = longint'($signed(y1));
            g.co     = co0;
            g.ovf    = ovf0;
            g.acc    = longint'($signed(acc0));
            got_q.push_back(g);
            cons_cyc_q.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_y_wrap", $signed(y0), e.y_wrap);
                chk("sb_y_sat", $signed(y1), e.y_sat);
                chk("sb_co", co0, longint'(e.co));
                chk("sb_ovf", ovf0, longint'(e.ovf));
                chk("sb_ovf_sat", ovf1, longint'(e.ovf));
                chk("sb_acc", $signed(acc0), e.acc);
                chk("sb_acc_sat", $signed(acc1), e.acc);
            end
        end
        if (last_acc) begin
            e = model(opcode, longint'($signed(A)), longint'($signed(B)), m_acc);
            m_acc = e.acc;
            sb.push_back(e);
            if (sb.size() > 2) chk("in_flight", sb.size(), 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        int n = 0;
        do begin
            tick(1'b1, op, a, b, 1'b1);
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick(1'b0, 3'd0, '0, '0, 1'b1);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'd7, 16'd0,     16'd0,     0,      0,      0, 0, 0};
        tbl[1]  = '{3'd0, 16'd32767, 16'd1,     -32768, 32767,  0, 1, 0};
        tbl[2]  = '{3'd0, 16'h8000,  16'hFFFF,  32767,  -32768, 1, 1, 0};
        tbl[3]  = '{3'd1, 16'd5,     16'd7,     -2,     -2,     0, 0, 0};
        tbl[4]  = '{3'd1, 16'd7,     16'd5,     2,      2,      1, 0, 0};
        tbl[5]  = '{3'd1, 16'd0,     16'h8000,  -32768, 32767,  0, 1, 0};
        tbl[6]  = '{3'd2, 16'hF0F0,  16'h0FF0,  240,    240,    0, 0, 0};
        tbl[7]  = '{3'd3, 16'hF0F0,  16'h0FF0,  -16,    -16,    0, 0, 0};
        tbl[8]  = '{3'd4, 16'hF0F0,  16'h0FF0,  -256,   -256,   0, 0, 0};
        tbl[9]  = '{3'd5, 16'd300,   16'd200,   -5536,  32767,  0, 1, 0};
        tbl[10] = '{3'd5, 16'hFFFD,  16'd4,     -12,    -12,    0, 0, 0};
        tbl[11] = '{3'd5, 16'h8000,  16'h8000,  0,      32767,  0, 1, 0};
        tbl[12] = '{3'd6, 16'd3,     16'd4,     12,     12,     0, 0, 12};
        tbl[13] = '{3'd6, 16'hFFFE,  16'd5,     2,      2,      0, 0, 2};
        tbl[14] = '{3'd6, 16'd100,   16'd100,   10002,  10002,  0, 0, 10002};
        tbl[15] = '{3'd7, 16'd0,     16'd0,     10002,  10002,  0, 0, 0};
        tbl[16] = '{3'd6, 16'd200,   16'd200,   -25536, 32767,  0, 0, 40000};
        tbl[17] = '{3'd6, 16'hFF38,  16'd400,   25536,  -32768, 0, 0, -40000};
        tbl[18] = '{3'd7, 16'd0,     16'd0,     25536,  -32768, 0, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_y", $signed(y0), 0);
        chk("rst_co", co0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_acc", $signed(acc0), 0);
        chk("rst_in_ready", in_ready0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_in_ready", in_ready0, 1);
        @(posedge clk);
        #1;

        // Vector table, back-to-back beats
        got_q.delete();
        for (int k = 0; k < 19; k++) send(tbl[k].op, tbl[k].a, tbl[k].b);
        drain();
        chk("tbl_count", got_q.size(), 19);
        if (got_q.size() == 19) begin
            for (int k = 0; k < 19; k++) begin
                chk($sformatf("tbl%0d_y_wrap", k), got_q[k].y_wrap, tbl[k].yw);
                chk($sformatf("tbl%0d_y_sat", k), got_q[k].y_sat, tbl[k].ys);
                chk($sformatf("tbl%0d_co", k), longint'(got_q[k].co), longint'(tbl[k].co));
                chk($sformatf("tbl%0d_ovf", k), longint'(got_q[k].ovf), longint'(tbl[k].ovf));
                chk($sformatf("tbl%0d_acc", k), got_q[k].acc, tbl[k].acc);
            end
        end

        // Backpressure: 5 ADD beats, out_ready low in cycles 3..6
        got_q.delete();
        bp_i = 1;
        for (int c = 1; c <= 30 && (bp_i <= 5 || sb.size() != 0); c++) begin
            tick(bp_i <= 5, 3'd0, 16'(bp_i), 16'(bp_i), !(c >= 3 && c <= 6));
            if (last_acc) bp_i++;
            if (c >= 3 && c <= 6) begin
                chk($sformatf("stall%0d_out_valid", c), snap_valid, 1);
                chk($sformatf("stall%0d_y", c), snap_y, 2);
                chk($sformatf("stall%0d_in_ready", c), snap_ready, 0);
            end
        end
        chk("bp_count", got_q.size(), 5);
        if (got_q.size() == 5) begin
            for (int k = 0; k < 5; k++)
                chk($sformatf("bp_y%0d", k), got_q[k].y_wrap, 2 * (k + 1));
        end

        // Throughput and latency: 8 consecutive beats
        cons_cyc_q.delete();
        for (int k = 0; k < 8; k++) begin
            send(3'd0, 16'(k), 16'd1);
            acc_cyc[k] = cyc;
        end
        drain();
        chk("tp_count", cons_cyc_q.size(), 8);
        if (cons_cyc_q.size() == 8) begin
            chk("tp_latency", cons_cyc_q[0] - acc_cyc[0], 2);
            for (int k = 1; k < 8; k++) begin
                chk($sformatf("tp_accept_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 1);
                chk($sformatf("tp_result_gap%0d", k), cons_cyc_q[k] - cons_cyc_q[k-1], 1);
            end
        end

        // Accumulator overflow: 512 MACs of 2^30 reach 2^39 and wrap
        got_q.delete();
        send(3'd7, '0, '0);
        for (int k = 0; k < 512; k++) send(3'd6, 16'h8000, 16'h8000);
        send(3'd7, '0, '0);
        drain();
        n_ovf = 0;
        foreach (got_q[k]) if (got_q[k].ovf) n_ovf++;
        chk("acc_ovf_count", n_ovf, 1);

        // Randomized traffic with random stalls and bubbles
        for (int k = 0; k < 400; k++)
            tick($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick(),
                 $urandom_range(0, 3) != 0);
        drain();

        // Reset mid-stream with acc=500 and two MAC beats in flight
        send(3'd7, '0, '0);
        send(3'd6, 16'd20, 16'd25);
        drain();
        tick(1'b1, 3'd6, 16'd0, 16'd7, 1'b0);
        tick(1'b1, 3'd6, 16'd0, 16'd9, 1'b0);
        chk("pre_rst_in_flight", sb.size(), 2);
        chk("pre_rst_out_valid", out_valid0, 1);
        chk("pre_rst_acc", $signed(acc0), 500);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid0, 0);
        chk("mid_rst_acc", $signed(acc0), 0);
        chk("mid_rst_acc_sat", $signed(acc1), 0);
        chk("mid_rst_in_ready", in_ready0, 0);
        sb.delete();
        m_acc = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
        send(3'd6, 16'd1, 16'd1);
        drain();
        chk("post_rst_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("post_rst_y", got_q[0].y_wrap, 1);
            chk("post_rst_acc", got_q[0].acc, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
